seq_1011_gen: RTL and testbench

- Moore-style serial pattern transmitter.
- Emits a programmable number of back-to-back frames of a fixed bit pattern (default 1011), MSB first, one bit per clock.
- Optional zero-filler gap between frames.
- Produces the stimulus stream consumed by the team's 1011 sequence detectors; each transmitted frame yields exactly one detection downstream.

---
 rtl/seq_1011_gen.sv | 103 ++++++++++
 tb/tb_seq_1011_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_1011_gen.sv
// Moore serial transmitter: sends nframes copies of PATTERN MSB first, with GAP filler zeros between frames.
// Define SEQ_GEN_ABORT_EN to add an abort input that cancels a transfer in SEND or GAP without a done pulse.
module seq_1011_gen #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               CNT_W   = 8,
   parameter int               GAP     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SEQ_GEN_ABORT_EN
   input  logic             abort,
`endif
   input  logic [CNT_W-1:0] nframes,
   output logic             out,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = $clog2(PAT_W);
   localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [BIT_W-1:0] bit_q,   bit_d;
   logic [CNT_W-1:0] frm_q,   frm_d;
   logic [GAP_W-1:0] gap_q,   gap_d;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      frm_d   = frm_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (start && (nframes != '0)) begin
               frm_d   = nframes;
               bit_d   = BIT_LAST;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (bit_q == '0) begin
               frm_d = frm_q - CNT_W'(1);
               // frm_q still counts the frame whose last bit is on out now
               if (frm_q == CNT_W'(1)) begin
                  state_d = S_DONE;
               end else if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LAST;
               end else begin
                  bit_d = BIT_LAST;
               end
            end else begin
               bit_d = bit_q - BIT_W'(1);
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_SEND;
               bit_d   = BIT_LAST;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef SEQ_GEN_ABORT_EN
      if (abort && ((state_q == S_SEND) || (state_q == S_GAP))) begin
         state_d = S_IDLE;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         frm_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         frm_q   <= frm_d;
         gap_q   <= gap_d;
      end
   end

   assign out   = (state_q == S_SEND) && PATTERN[bit_q];
   assign valid = (state_q == S_SEND) || (state_q == S_GAP);
   assign busy  = (state_q == S_SEND) || (state_q == S_GAP);
   assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_1011_gen.sv
// Bench for seq_1011_gen: GAP=0 and GAP=2 instances checked every cycle against an arithmetic
// frame/offset model, plus literal stream, length and detector-count expectations.
module tb_seq_1011_gen;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [7:0] nframes;
   logic       out0, valid0, busy0, done0;
   logic       out1, valid1, busy1, done1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_1011_gen #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_GEN_ABORT_EN
      .abort(abort),
`endif
      .nframes(nframes), .out(out0), .valid(valid0), .busy(busy0), .done(done0)
   );

   seq_1011_gen #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .GAP(2)) dut1 (
      .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_GEN_ABORT_EN
      .abort(abort),
`endif
      .nframes(nframes), .out(out1), .valid(valid1), .busy(busy1), .done(done1)
   );

   // Model: a transfer is nf frames of period 4+g; k is the cycle offset from its first bit.
   function automatic int xfer_len(int nf, int g);
      return nf * 4 + (nf - 1) * g;
   endfunction

   function automatic logic [3:0] expv(int k, int nf, int g);
      logic [3:0] pv;
      int p;
      pv = 4'b1011;
      if (k < xfer_len(nf, g)) begin
         p = k % (4 + g);
         if (p < 4) return {pv[3 - p], 3'b110};
         return 4'b0110;
      end
      if (k == xfer_len(nf, g)) return 4'b0001;
      return 4'b0000;
   endfunction

   bit act0 = 1'b0, act1 = 1'b0;
   int k0 = 0, k1 = 0, nf0 = 0, nf1 = 0;

   always @(posedge clk) begin
      if (rst) begin
         act0 <= 1'b0;
      end else if (act0) begin
         if (k0 >= xfer_len(nf0, 0) || (abort && k0 < xfer_len(nf0, 0))) act0 <= 1'b0;
         k0 <= k0 + 1;
      end else if (start && nframes != 8'd0) begin
         act0 <= 1'b1; k0 <= 0; nf0 <= int'(nframes);
      end
      if (rst) begin
         act1 <= 1'b0;
      end else if (act1) begin
         if (k1 >= xfer_len(nf1, 2) || (abort && k1 < xfer_len(nf1, 2))) act1 <= 1'b0;
         k1 <= k1 + 1;
      end else if (start && nframes != 8'd0) begin
         act1 <= 1'b1; k1 <= 0; nf1 <= int'(nframes);
      end
   end

   // Observed-stream statistics used by the literal expectations.
   logic [31:0] str0, str1;
   logic [3:0]  sh0, sh1;
   int bc0, bc1, dn0, dn1, hit0, hit1;

   always @(negedge clk) begin
      logic [3:0] e0, e1, n0, n1;
      e0 = act0 ? expv(k0, nf0, 0) : 4'b0000;
      e1 = act1 ? expv(k1, nf1, 2) : 4'b0000;
      checks = checks + 2;
      if ({out0, valid0, busy0, done0} !== e0) begin
         errors = errors + 1;
         $display("FAIL gap0_outputs t=%0t {out,valid,busy,done} got %b want %b", $time,
                  {out0, valid0, busy0, done0}, e0);
      end
      if ({out1, valid1, busy1, done1} !== e1) begin
         errors = errors + 1;
         $display("FAIL gap2_outputs t=%0t {out,valid,busy,done} got %b want %b", $time,
                  {out1, valid1, busy1, done1}, e1);
      end
      if (valid0) begin
         str0 = {str0[30:0], out0};
         n0 = {sh0[2:0], out0};
         sh0 = n0;
         if (n0 == 4'b1011) hit0 = hit0 + 1;
      end
      if (valid1) begin
         str1 = {str1[30:0], out1};
         n1 = {sh1[2:0], out1};
         sh1 = n1;
         if (n1 == 4'b1011) hit1 = hit1 + 1;
      end
      if (busy0) bc0 = bc0 + 1;
      if (busy1) bc1 = bc1 + 1;
      if (done0) dn0 = dn0 + 1;
      if (done1) dn1 = dn1 + 1;
   end

   task automatic clr();
      str0 = '0; str1 = '0; sh0 = '0; sh1 = '0;
      bc0 = 0; bc1 = 0; dn0 = 0; dn1 = 0; hit0 = 0; hit1 = 0;
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(int nf);
      start = 1'b1; nframes = 8'(nf);
      cyc(1);
      start = 1'b0; nframes = 8'd0;
   endtask

   task automatic chk(string name, int act, int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; nframes = 8'd0;
      clr();
      cyc(2);
      chk("reset_busy_cycles", bc0 + bc1, 0);
      chk("reset_done_pulses", dn0 + dn1, 0);
      rst = 1'b0;
      cyc(2);

      clr(); pulse(1); cyc(8);
      chk("single_stream", int'(str0[3:0]), 'b1011);
      chk("single_busy", bc0, 4);
      chk("single_done", dn0, 1);
      chk("single_hits", hit0, 1);
      chk("single_busy_gap2", bc1, 4);

      clr(); pulse(3); cyc(20);
      chk("b2b_stream", int'(str0[11:0]), 'b101110111011);
      chk("b2b_busy", bc0, 12);
      chk("b2b_hits", hit0, 3);
      chk("b2b_done", dn0, 1);
      chk("gap2_3f_busy", bc1, 16);

      clr(); pulse(2); cyc(16);
      chk("gap2_stream", int'(str1[9:0]), 'b1011001011);
      chk("gap2_busy", bc1, 10);
      chk("gap2_hits", hit1, 2);
      chk("gap2_done", dn1, 1);

      clr(); pulse(0); cyc(6);
      chk("zero_req_busy", bc0 + bc1, 0);
      chk("zero_req_done", dn0 + dn1, 0);

      clr(); pulse(2); cyc(3); pulse(5); cyc(20);
      chk("ignored_start_busy", bc0, 8);
      chk("ignored_start_gap2_busy", bc1, 10);
      chk("ignored_start_done", dn0, 1);

      clr(); pulse(2); cyc(1);
      rst = 1'b1; cyc(1); rst = 1'b0; cyc(10);
      chk("rst_mid_busy", bc0, 2);
      chk("rst_mid_done", dn0 + dn1, 0);

`ifdef SEQ_GEN_ABORT_EN
      clr(); pulse(2); cyc(1);
      abort = 1'b1; cyc(1); abort = 1'b0; cyc(10);
      chk("abort_mid_busy", bc0, 2);
      chk("abort_mid_done", dn0 + dn1, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         start   = ($urandom % 4) == 0;
         nframes = 8'($urandom % 6);
         rst     = ($urandom % 200) == 0;
`ifdef SEQ_GEN_ABORT_EN
         abort   = ($urandom % 150) == 0;
`endif
         cyc(1);
      end
      start = 1'b0; rst = 1'b0; abort = 1'b0; nframes = 8'd0;
      cyc(50);

      clr(); pulse(255); cyc(1600);
      chk("max_busy", bc0, 1020);
      chk("max_hits", hit0, 255);
      chk("max_done", dn0, 1);
      chk("max_gap2_busy", bc1, 1528);
      chk("max_gap2_done", dn1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
